// File: rtl/usb_bit_encoder.sv
// USB serial transmit stage: takes one 99-bit packet, sends it as NRZI with bit
// stuffing and an appended CRC5/CRC16, then drives SE0/J end-of-packet.
module usb_bit_encoder #(
    parameter int STUFF_LEN   = 6,
    parameter int EOP_SE0_LEN = 2
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic [98:0] pkt_in,
    input  logic        pkt_in_avail,
    output logic        nrzi_out,
    output logic        se0,
    output logic        out_en,
    output logic        pkt_sent,
    output logic        busy
);
    localparam int            SW        = $clog2(STUFF_LEN + 1);
    localparam logic [SW-1:0] STUFF_MAX = SW'(STUFF_LEN);
    localparam logic [6:0]    EOP_LAST  = 7'(EOP_SE0_LEN);

    typedef enum logic [2:0] {IDLE, SYNC_PID, PAYLOAD, CRC, EOP_SE0, EOP_J} state_t;

    // state/bit_cnt describe the bit currently on the line; the comb block
    // picks the bit that goes out next.
    state_t        state, nxt_field, tgt;
    logic [98:0]   sr;
    logic [6:0]    bit_cnt, field_len;
    logic [SW-1:0] ones;
    logic [15:0]   crc, crc_base, crc_nx;
    logic [1:0]    cls;
    logic          hs, tok, field_done, stuff_due, dbit, fb;

    assign hs        = ~cls[0];
    assign tok       = (cls == 2'b01);
    assign stuff_due = (ones == STUFF_MAX);
    assign busy      = (state != IDLE);
    assign out_en    = busy;

    always_comb begin
        field_len = 7'd16;
        nxt_field = EOP_SE0;
        case (state)
            SYNC_PID: nxt_field = hs ? EOP_SE0 : PAYLOAD;
            PAYLOAD: begin
                field_len = tok ? 7'd11 : 7'd64;
                nxt_field = CRC;
            end
            CRC:     field_len = tok ? 7'd5 : 7'd16;
            default: ;
        endcase
        field_done = (bit_cnt == field_len);
        tgt        = field_done ? nxt_field : state;
        // the register is seeded only when the first payload bit goes out
        crc_base   = (state != PAYLOAD) ? (tok ? 16'h001F : 16'hFFFF) : crc;
        dbit       = (tgt == CRC) ? ~(tok ? crc[4] : crc[15]) : sr[98];
        fb         = dbit ^ (tok ? crc_base[4] : crc_base[15]);
        crc_nx     = {crc_base[14:0], 1'b0} ^ (fb ? (tok ? 16'h0005 : 16'h8005) : 16'h0000);
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state    <= IDLE;
            sr       <= '0;
            bit_cnt  <= '0;
            ones     <= '0;
            crc      <= '0;
            cls      <= '0;
            nrzi_out <= 1'b1;
            se0      <= 1'b0;
            pkt_sent <= 1'b0;
        end else begin
            pkt_sent <= 1'b0;
            case (state)
                IDLE: if (pkt_in_avail) begin
                    state    <= SYNC_PID;
                    cls      <= pkt_in[84:83];
                    sr       <= {pkt_in[97:0], 1'b0};
                    nrzi_out <= pkt_in[98];  // line idles at J, a 0 toggles to K
                    bit_cnt  <= 7'd1;
                    ones     <= SW'(pkt_in[98]);
                end
                SYNC_PID, PAYLOAD, CRC: begin
                    if (stuff_due) begin
                        nrzi_out <= ~nrzi_out;
                        ones     <= '0;
                    end else if (tgt == EOP_SE0) begin
                        state   <= EOP_SE0;
                        se0     <= 1'b1;
                        bit_cnt <= 7'd1;
                        ones    <= '0;
                    end else begin
                        state   <= tgt;
                        bit_cnt <= field_done ? 7'd1 : bit_cnt + 7'd1;
                        ones    <= dbit ? ones + SW'(1) : '0;
                        if (!dbit)
                            nrzi_out <= ~nrzi_out;
                        if (tgt != CRC)
                            sr <= sr << 1;
                        if (tgt == PAYLOAD)
                            crc <= crc_nx;
                        else
                            crc <= crc << 1;
                    end
                end
                EOP_SE0: begin
                    if (bit_cnt == EOP_LAST) begin
                        state    <= EOP_J;
                        se0      <= 1'b0;
                        nrzi_out <= 1'b1;
                        pkt_sent <= 1'b1;
                    end else begin
                        bit_cnt <= bit_cnt + 7'd1;
                    end
                end
                EOP_J: begin
                    state   <= IDLE;
                    bit_cnt <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_usb_bit_encoder.sv
// Scoreboard bench: a reference model queues the expected de-stuffed bit stream;
// a line monitor decodes NRZI, strips stuff bits and pops/compares each bit.
module tb_usb_bit_encoder;
    logic        clk = 1'b0;
    logic        rst_b = 1'b0;
    logic [98:0] pkt_in = '0;
    logic        pkt_in_avail = 1'b0;
    logic        nrzi_out, se0, out_en, pkt_sent, busy;

    int checks = 0, errors = 0;
    bit exp_q[$];
    bit rx_q[$];
    int mon_ones = 0, mon_stuff = 0, sent_cnt = 0;
    logic mon_prev = 1'b1;

    usb_bit_encoder #(.STUFF_LEN(6), .EOP_SE0_LEN(2)) dut (
        .clk(clk), .rst_b(rst_b), .pkt_in(pkt_in), .pkt_in_avail(pkt_in_avail),
        .nrzi_out(nrzi_out), .se0(se0), .out_en(out_en), .pkt_sent(pkt_sent), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin : monitor
        bit b, e;
        if (rst_b && pkt_sent)
            sent_cnt++;
        if (!rst_b || !out_en || se0) begin
            mon_prev = 1'b1;
            mon_ones = 0;
        end else if (!pkt_sent) begin
            b = (nrzi_out == mon_prev);
            mon_prev = nrzi_out;
            checks++;
            if (mon_ones == 6) begin
                mon_stuff++;
                mon_ones = 0;
                if (b) begin
                    errors++;
                    $display("FAIL stuff_bit: got 1 expected 0 at t=%0t", $time);
                end
            end else begin
                mon_ones = b ? mon_ones + 1 : 0;
                rx_q.push_back(b);
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL extra_bit: got bit %0d with nothing expected at t=%0t", b, $time);
                end else begin
                    e = exp_q.pop_front();
                    if (b !== e) begin
                        errors++;
                        $display("FAIL line_bit[%0d]: got %0d expected %0d", rx_q.size() - 1, b, e);
                    end
                end
            end
        end
    end

    // Test-plan PID literals list the first wire bit in the LSB.
    function automatic logic [7:0] rev8(input logic [7:0] v);
        for (int i = 0; i < 8; i++) rev8[i] = v[7-i];
    endfunction

    task automatic model_push(input logic [98:0] p, output int nbits, output int nstuff);
        bit raw[$];
        logic [4:0] c5;
        logic [15:0] c16;
        int pay, cw, run;
        logic b;
        pay = (p[84:83] == 2'b01) ? 11 : (p[84:83] == 2'b11) ? 64 : 0;
        cw  = (p[84:83] == 2'b01) ? 5  : (p[84:83] == 2'b11) ? 16 : 0;
        for (int i = 0; i < 16; i++) raw.push_back(p[98-i]);
        c5 = 5'h1F;
        c16 = 16'hFFFF;
        for (int i = 0; i < pay; i++) begin
            b = p[82-i];
            raw.push_back(b);
            c5  = (b ^ c5[4])  ? ({c5[3:0], 1'b0} ^ 5'h05)    : {c5[3:0], 1'b0};
            c16 = (b ^ c16[15]) ? ({c16[14:0], 1'b0} ^ 16'h8005) : {c16[14:0], 1'b0};
        end
        if (cw == 5)  for (int i = 4; i >= 0; i--)  raw.push_back(~c5[i]);
        if (cw == 16) for (int i = 15; i >= 0; i--) raw.push_back(~c16[i]);
        run = 0;
        nstuff = 0;
        foreach (raw[i]) begin
            exp_q.push_back(raw[i]);
            if (raw[i]) begin
                run++;
                if (run == 6) begin nstuff++; run = 0; end
            end else run = 0;
        end
        nbits = raw.size();
    endtask

    // CRC over received payload+CRC bits; a correct field leaves the fixed residual.
    function automatic logic [15:0] rx_residual(input int cw);
        logic [15:0] c;
        logic b;
        c = (cw == 5) ? 16'h001F : 16'hFFFF;
        for (int i = 16; i < rx_q.size(); i++) begin
            b = rx_q[i];
            if (cw == 5) c[4:0] = (b ^ c[4]) ? ({c[3:0], 1'b0} ^ 5'h05) : {c[3:0], 1'b0};
            else         c = (b ^ c[15]) ? ({c[14:0], 1'b0} ^ 16'h8005) : {c[14:0], 1'b0};
        end
        return (cw == 5) ? {11'h0, c[4:0]} : c;
    endfunction

    task automatic xmit(input logic [98:0] p, output int lat, output int ns);
        int nb;
        @(negedge clk);
        rx_q.delete();
        mon_stuff = 0;
        model_push(p, nb, ns);
        pkt_in = p;
        pkt_in_avail = 1'b1;
        @(posedge clk);
        lat = -1;
        for (int i = 1; i <= 400; i++) begin
            @(negedge clk);
            if (pkt_sent) begin lat = i; break; end
        end
        pkt_in_avail = 1'b0;
    endtask

    task automatic test_reset;
        pkt_in = {8'h01, rev8(8'b01001011), 83'h0};
        pkt_in_avail = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({nrzi_out, se0, out_en, pkt_sent, busy} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 10000", {nrzi_out, se0, out_en, pkt_sent, busy});
        end
        pkt_in_avail = 1'b0;
        rst_b = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({out_en, busy, pkt_sent} !== 3'b000) begin
            errors++;
            $display("FAIL reset_release_idle: got %b expected 000", {out_en, busy, pkt_sent});
        end
    endtask

    task automatic test_handshake;
        int lat, ns;
        xmit({8'h01, rev8(8'b01001011), 83'h0}, lat, ns);
        checks++;
        if (lat !== 19) begin errors++; $display("FAIL ack_latency: got %0d expected 19", lat); end
        checks++;
        if (rx_q.size() != 16) begin errors++; $display("FAIL ack_bits: got %0d expected 16", rx_q.size()); end
        checks++;
        if (mon_stuff != 0) begin errors++; $display("FAIL ack_stuff: got %0d expected 0", mon_stuff); end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL ack_pending: got %0d expected 0", exp_q.size()); end
    endtask

    task automatic test_token;
        int lat, ns;
        logic [15:0] r;
        xmit({8'h01, rev8(8'b10000111), 11'h000, 72'h0}, lat, ns);
        checks++;
        if (lat !== 35) begin errors++; $display("FAIL token_latency: got %0d expected 35", lat); end
        checks++;
        if (rx_q.size() != 32) begin errors++; $display("FAIL token_bits: got %0d expected 32", rx_q.size()); end
        r = rx_residual(5);
        checks++;
        if (r !== 16'h000C) begin errors++; $display("FAIL token_crc5_residual: got %h expected 000c", r); end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL token_pending: got %0d expected 0", exp_q.size()); end
    endtask

    task automatic test_data;
        int lat, ns;
        logic [15:0] r;
        logic [63:0] pay;
        for (int k = 0; k < 2; k++) begin
            pay = (k == 0) ? {64{1'b1}} : {$urandom(), $urandom()};
            xmit({8'h01, rev8(8'b11000011), pay, 19'h0}, lat, ns);
            checks++;
            if (lat !== 16 + 64 + 16 + ns + 3) begin
                errors++; $display("FAIL data%0d_latency: got %0d expected %0d", k, lat, 99 + ns);
            end
            checks++;
            if (mon_stuff != ns) begin
                errors++; $display("FAIL data%0d_stuff_count: got %0d expected %0d", k, mon_stuff, ns);
            end
            r = rx_residual(16);
            checks++;
            if (r !== 16'h800D) begin errors++; $display("FAIL data%0d_crc16_residual: got %h expected 800d", k, r); end
            checks++;
            if (exp_q.size() != 0) begin errors++; $display("FAIL data%0d_pending: got %0d expected 0", k, exp_q.size()); end
        end
    endtask

    task automatic test_back_to_back;
        logic [98:0] p1, p2;
        int nb, ns1, ns2, lat1, lat2, s0;
        p1 = {8'h01, rev8(8'b10000111), 11'h5A3, 72'h0};
        p2 = {8'h01, rev8(8'b11000011), {$urandom(), $urandom()}, 19'h0};
        @(negedge clk);
        s0 = sent_cnt;
        model_push(p1, nb, ns1);
        model_push(p2, nb, ns2);
        pkt_in = p1;
        pkt_in_avail = 1'b1;
        @(posedge clk);
        @(negedge clk);
        pkt_in = p2;  // changes while the token is in flight
        lat1 = -1;
        for (int i = 2; i <= 400; i++) begin
            if (pkt_sent) begin lat1 = i - 1; break; end
            @(negedge clk);
        end
        checks++;
        if (lat1 !== 32 + ns1 + 3) begin errors++; $display("FAIL b2b_token_latency: got %0d expected %0d", lat1, 35 + ns1); end
        @(negedge clk);
        checks++;
        if ({out_en, busy} !== 2'b00) begin errors++; $display("FAIL b2b_idle_gap: got %b expected 00", {out_en, busy}); end
        lat2 = -1;
        for (int i = 1; i <= 400; i++) begin
            @(negedge clk);
            if (i == 1) begin
                checks++;
                if (out_en !== 1'b1) begin errors++; $display("FAIL b2b_data_start: got %b expected 1", out_en); end
            end
            if (pkt_sent) begin lat2 = i; break; end
        end
        pkt_in_avail = 1'b0;
        checks++;
        if (lat2 !== 96 + ns2 + 3) begin errors++; $display("FAIL b2b_data_latency: got %0d expected %0d", lat2, 99 + ns2); end
        repeat (4) @(negedge clk);
        checks++;
        if (sent_cnt - s0 != 2) begin errors++; $display("FAIL b2b_sent_pulses: got %0d expected 2", sent_cnt - s0); end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_pending: got %0d expected 0", exp_q.size()); end
    endtask

    task automatic test_reset_mid_packet;
        logic [98:0] p;
        int nb, ns, lat, s0;
        p = {8'h01, rev8(8'b11000011), {$urandom(), $urandom()}, 19'h0};
        @(negedge clk);
        model_push(p, nb, ns);
        pkt_in = p;
        pkt_in_avail = 1'b1;
        @(posedge clk);
        repeat (30) @(negedge clk);
        @(posedge clk);
        #2;
        rst_b = 1'b0;
        pkt_in_avail = 1'b0;
        exp_q.delete();
        s0 = sent_cnt;
        #1;
        checks++;
        if ({nrzi_out, se0, out_en, pkt_sent, busy} !== 5'b10000) begin
            errors++;
            $display("FAIL midreset_outputs: got %b expected 10000", {nrzi_out, se0, out_en, pkt_sent, busy});
        end
        @(negedge clk);
        #1 rst_b = 1'b1;
        repeat (120) @(negedge clk);
        checks++;
        if (sent_cnt != s0) begin errors++; $display("FAIL midreset_no_sent: got %0d pulses expected 0", sent_cnt - s0); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL midreset_idle: got busy=%b expected 0", busy); end
        xmit({8'h01, rev8(8'b01001011), 83'h0}, lat, ns);
        checks++;
        if (lat !== 19) begin errors++; $display("FAIL midreset_next_latency: got %0d expected 19", lat); end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL midreset_next_pending: got %0d expected 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_handshake();
        test_token();
        test_data();
        test_back_to_back();
        test_reset_mid_packet();
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
